// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared codes, state encoding and control decode for serial_alu
package serial_alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
  } slice_ctrl_t;

  function automatic slice_ctrl_t decode_ctrl(input logic [3:0] ctrl);
    slice_ctrl_t s;
    s = '{legal: 1'b1, a_inv: 1'b0, b_inv: 1'b0, op: OP_AND};
    case (ctrl)
      CTRL_AND: s.op = OP_AND;
      CTRL_OR:  s.op = OP_OR;
      CTRL_ADD: s.op = OP_ADD;
      CTRL_SUB: begin s.b_inv = 1'b1; s.op = OP_ADD; end
      CTRL_SLT: begin s.b_inv = 1'b1; s.op = OP_LESS; end
      CTRL_NOR: begin s.a_inv = 1'b1; s.b_inv = 1'b1; s.op = OP_AND; end
      default:  s.legal = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// rtl/serial_alu_bit.sv - combinational 1-bit ALU slice
module serial_alu_bit
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout
);

  logic a_m, b_m, sum;

  assign a_m  = a ^ a_invert;
  assign b_m  = b ^ b_invert;
  assign sum  = a_m ^ b_m ^ cin;
  assign cout = (a_m & b_m) | (a_m & cin) | (b_m & cin);

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = a_m & b_m;
      OP_OR:   result = a_m | b_m;
      OP_ADD:  result = sum;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU: one slice, registered carry, LSB-first over WIDTH cycles
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  slice_ctrl_t      sc;
  logic             slice_res, slice_cout, sum_msb, ovf_fin, last_bit;
  logic [WIDTH-1:0] shifted;

  assign sc = decode_ctrl(ctrl_q);

  serial_alu_bit u_bit (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .less     (1'b0),
    .a_invert (sc.a_inv),
    .b_invert (sc.b_inv),
    .cin      (carry_q),
    .op       (sc.op),
    .result   (slice_res),
    .cout     (slice_cout)
  );

  // SLT needs the raw MSB sum even though the slice output carries 'less' in that mode
  assign sum_msb  = (a_q[0] ^ sc.a_inv) ^ (b_q[0] ^ sc.b_inv) ^ carry_q;
  assign ovf_fin  = carry_q ^ slice_cout;
  assign shifted  = {slice_res, acc_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    ctrl_d   = ctrl_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = src1_i;
          b_d     = src2_i;
          ctrl_d  = ctrl_i;
          cnt_d   = '0;
          carry_d = decode_ctrl(ctrl_i).b_inv;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = shifted;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d  = ST_DONE;
          result_d = shifted;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          if (!sc.legal) begin
            result_d = '0;
          end else if (sc.op == OP_ADD) begin
            cout_d = slice_cout;
            ovf_d  = ovf_fin;
          end else if (sc.op == OP_LESS) begin
            result_d = {{(WIDTH-1){1'b0}}, sum_msb ^ ovf_fin};
          end
          zero_d = (result_d == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      ctrl_q   <= ctrl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - scoreboard bench for serial_alu
module tb_serial_alu;

  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   ctrl_i = '0;
  logic [W-1:0] src1_i = '0, src2_i = '0;
  logic [W-1:0] result_o;
  logic         zero_o, cout_o, overflow_o, busy_o, done_o;

  serial_alu #(.WIDTH(W), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .result_o(result_o), .zero_o(zero_o),
    .cout_o(cout_o), .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] t;
    e.res = '0; e.c = 1'b0; e.v = 1'b0;
    case (c)
      C_AND: e.res = a & b;
      C_OR:  e.res = a | b;
      C_NOR: e.res = ~(a | b);
      C_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        e.res = t[W-1:0]; e.c = t[W];
        e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      C_SUB: begin
        t = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = t[W-1:0]; e.c = t[W];
        e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      C_SLT: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Returns at the first negedge after the accepting edge; operands are scrambled afterwards.
  task automatic start_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    sb.push_back(model(c, a, b));
    @(negedge clk_i);
    start_i = 1'b0; ctrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done_o !== 1'b1 && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic score(input string name, input int lat);
    exp_t e;
    tests_run++;
    if (lat >= 100 || sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: no done pulse (lat=%0d, pending=%0d)", name, lat, sb.size());
      return;
    end
    e = sb.pop_front();
    tests_run++;
    if (result_o !== e.res) begin
      tests_failed++;
      $display("FAIL %s result: got %h want %h", name, result_o, e.res);
    end
    tests_run++;
    if ({zero_o, cout_o, overflow_o} !== {e.z, e.c, e.v}) begin
      tests_failed++;
      $display("FAIL %s flags z/c/v: got %b%b%b want %b%b%b", name, zero_o, cout_o, overflow_o, e.z, e.c, e.v);
    end
    @(negedge clk_i);
    tests_run++;
    if (done_o !== 1'b0 || result_o !== e.res) begin
      tests_failed++;
      $display("FAIL %s after-done: done=%b result=%h want done=0 result=%h", name, done_o, result_o, e.res);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    tests_run++;
    if ({result_o, zero_o, cout_o, overflow_o, busy_o, done_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: result=%h z=%b c=%b v=%b busy=%b done=%b want all 0",
               result_o, zero_o, cout_o, overflow_o, busy_o, done_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_add_overflow;
    int lat;
    start_op(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL add busy: got %b want 1", busy_o);
    end
    wait_done(lat);
    tests_run++;
    if (lat != 33) begin
      tests_failed++;
      $display("FAIL add latency: got %0d want 33", lat);
    end
    score("add_ovf", lat);
  endtask

  task automatic test_sub;
    int lat;
    start_op(C_SUB, 32'h5, 32'h5);         wait_done(lat); score("sub_eq", lat);
    start_op(C_SUB, 32'h0, 32'h1);         wait_done(lat); score("sub_neg", lat);
    start_op(C_ADD, 32'hFFFF_FFFF, 32'h2); wait_done(lat); score("add_carry", lat);
  endtask

  task automatic test_slt;
    int lat;
    start_op(C_SLT, 32'hFFFF_FFFF, 32'h0000_0001); wait_done(lat); score("slt_neg", lat);
    start_op(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000); wait_done(lat); score("slt_ovf", lat);
    start_op(C_SLT, 32'h8000_0000, 32'h7FFF_FFFF); wait_done(lat); score("slt_min", lat);
  endtask

  task automatic test_logic;
    int lat;
    start_op(C_NOR, 32'h0, 32'h0);                 wait_done(lat); score("nor", lat);
    start_op(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_done(lat); score("and", lat);
    start_op(C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00); wait_done(lat); score("or", lat);
  endtask

  task automatic test_illegal;
    int lat;
    start_op(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678); wait_done(lat); score("illegal", lat);
  endtask

  task automatic test_ignore_start;
    int pulses;
    logic [W-1:0] first_res;
    pulses = 0;
    first_res = '0;
    start_op(C_ADD, 32'h1111_1111, 32'h2222_2222);
    for (int lat = 1; lat < 60; lat++) begin
      if (done_o === 1'b1) begin
        if (pulses == 0) first_res = result_o;
        pulses++;
      end
      start_i = (lat == 5 || lat == 20);
      if (start_i) begin
        ctrl_i = C_SUB; src1_i = $urandom; src2_i = $urandom;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL ignore_start pulses: got %0d want 1", pulses);
    end
    tests_run++;
    if (sb.size() != 1 || first_res !== sb[0].res) begin
      tests_failed++;
      $display("FAIL ignore_start result: got %h want %h", first_res, (sb.size() != 0) ? sb[0].res : '0);
    end
    tests_run++;
    if (result_o !== first_res) begin
      tests_failed++;
      $display("FAIL ignore_start hold: got %h want %h", result_o, first_res);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_run;
    int lat, pulses;
    pulses = 0;
    start_op(C_ADD, 32'hAAAA_0000, 32'h0000_5555);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    tests_run++;
    if ({result_o, zero_o, cout_o, overflow_o, busy_o, done_o} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset outputs: result=%h z=%b c=%b v=%b busy=%b done=%b want all 0",
               result_o, zero_o, cout_o, overflow_o, busy_o, done_o);
    end
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) pulses++;
      if (i == 2) rst_i = 1'b1;
    end
    tests_run++;
    if (pulses != 0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset discard: pulses=%0d busy=%b want 0 0", pulses, busy_o);
    end
    start_op(C_ADD, 32'h3, 32'h4);
    wait_done(lat);
    tests_run++;
    if (lat != 33) begin
      tests_failed++;
      $display("FAIL post_reset latency: got %0d want 33", lat);
    end
    score("post_reset_add", lat);
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op((i % 2 == 0) ? C_ADD : C_SUB, $urandom, $urandom);
      wait_done(lat);
      score("b2b", lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_slt();
    test_logic();
    test_illegal();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
